// File: rtl/seq_tempo_pkg.sv
// -----------------------------------------------------------------------------
// seq_tempo_pkg
// Shared tempo definitions for the sequencer's step-clock generator and the
// tap tempo encoder. Both ends take their class thresholds, nominal periods and
// codes from here, so the encoder's classes cannot drift from the generator's
// bands.
//   NOMINAL_PERIOD : nominal step period (ticks) of each tempo class
//   CLASS_UPPER    : inclusive upper bound of classes 0..8 (class 9 is open)
//   CLASS_CODE     : user_input0 code placed mid-band for each class
//   DEFAULT_*      : power-on tempo (class 3, 100-tick period)
// -----------------------------------------------------------------------------
package seq_tempo_pkg;

  localparam int NUM_CLASSES = 10;

  localparam logic [9:0] DEFAULT_CODE  = 10'd350;
  localparam logic [3:0] DEFAULT_INDEX = 4'd3;

  localparam logic [15:0] NOMINAL_PERIOD [0:9] = '{
    16'd10, 16'd25, 16'd50, 16'd100, 16'd150,
    16'd200, 16'd250, 16'd300, 16'd350, 16'd400
  };

  // Each bound sits just below the rounded-up midpoint of neighbouring
  // nominal periods: class i+1 starts at (P[i] + P[i+1] + 1) >> 1.
  localparam logic [15:0] CLASS_UPPER [0:8] = '{
    16'd17, 16'd37, 16'd74, 16'd124, 16'd174,
    16'd224, 16'd274, 16'd324, 16'd374
  };

  localparam logic [9:0] CLASS_CODE [0:9] = '{
    10'd50, 10'd150, 10'd250, 10'd350, 10'd450,
    10'd550, 10'd650, 10'd750, 10'd850, 10'd960
  };

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_TRACKING = 2'd2
  } tap_state_e;

  // Period class of a measured interval (ticks).
  function automatic logic [3:0] class_of(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd9;
    for (int i = 8; i >= 0; i--) begin
      if (m <= CLASS_UPPER[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Generator code for a class; out-of-range indices map to the slowest band.
  function automatic logic [9:0] code_of(input logic [3:0] idx);
    logic [9:0] code;
    if (idx <= 4'd9) code = CLASS_CODE[idx];
    else             code = CLASS_CODE[9];
    return code;
  endfunction

endpackage

// File: rtl/tap_sync_debounce.sv
// -----------------------------------------------------------------------------
// tap_sync_debounce
// Brings the raw tap level into the clock domain, detects rising edges and
// suppresses further edges for DEBOUNCE_TICKS ticks after each accepted one.
//   i_clk    : tick clock
//   i_reset  : synchronous active-high reset
//   i_tap    : raw asynchronous tap level
//   o_accept : high for the cycle in which a rising edge is accepted
// -----------------------------------------------------------------------------
module tap_sync_debounce #(
  parameter int DEBOUNCE_TICKS = 5
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tap,
  output logic o_accept
);

  localparam int LW = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [LW-1:0] r_lockout;
  logic          w_rise;

  assign w_rise   = r_sync2 & ~r_prev;
  assign o_accept = w_rise & (r_lockout == '0);

  // Synchronizer, edge-detect flop and lockout countdown.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_prev    <= 1'b0;
      r_lockout <= '0;
    end else begin
      r_sync1 <= i_tap;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (o_accept) begin
        r_lockout <= LW'(DEBOUNCE_TICKS);
      end else if (r_lockout != '0) begin
        r_lockout <= r_lockout - LW'(1);
      end else begin
        r_lockout <= r_lockout;
      end
    end
  end

endmodule

// File: rtl/tap_tempo_encoder.sv
// -----------------------------------------------------------------------------
// tap_tempo_encoder
// Measures the interval between accepted taps and converts it into the tempo
// code that makes the step-clock generator reproduce that period.
//   i_clk100hz    : 100 Hz sequencer tick clock
//   i_reset       : synchronous active-high reset
//   i_tap         : raw tap-button level
//   o_tempo_code  : code for the generator's user_input0
//   o_tempo_index : period class 0..9
//   o_code_valid  : at least one interval measured since reset
//   o_tap_pulse   : one-cycle strobe per accepted tap
//   o_timeout     : one-cycle strobe when a measurement is abandoned
// -----------------------------------------------------------------------------
module tap_tempo_encoder
  import seq_tempo_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 5,
  parameter int TIMEOUT_TICKS  = 500,
  parameter int CNT_W          = 9
) (
  input  logic       i_clk100hz,
  input  logic       i_reset,
  input  logic       i_tap,
  output logic [9:0] o_tempo_code,
  output logic [3:0] o_tempo_index,
  output logic       o_code_valid,
  output logic       o_tap_pulse,
  output logic       o_timeout
);

  tap_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cur;
  logic [CNT_W-1:0] r_prev;
  logic [9:0]       r_code;
  logic [3:0]       r_index;
  logic             r_valid;
  logic             r_tap_pulse;
  logic             r_timeout;

  logic             w_accept;
  logic             w_expired;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_avg;
  logic [3:0]       w_raw_idx;
  logic [3:0]       w_avg_idx;

  tap_sync_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_sync (
    .i_clk   (i_clk100hz),
    .i_reset (i_reset),
    .i_tap   (i_tap),
    .o_accept(w_accept)
  );

  // r_cnt already holds the interval on the accepting edge: it is loaded
  // with 1 on the previous acceptance and counts every edge since.
  // The average uses the new history: prev<=cur, cur<=r_cnt.
  assign w_expired = (r_cnt == CNT_W'(TIMEOUT_TICKS));
  assign w_sum     = {1'b0, r_cur} + {1'b0, r_cnt};
  assign w_avg     = w_sum[CNT_W:1];
  assign w_raw_idx = class_of(16'(r_cnt));
  assign w_avg_idx = class_of(16'(w_avg));

  // Measurement FSM with registered outputs.
  always_ff @(posedge i_clk100hz) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cur       <= '0;
      r_prev      <= '0;
      r_code      <= DEFAULT_CODE;
      r_index     <= DEFAULT_INDEX;
      r_valid     <= 1'b0;
      r_tap_pulse <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_tap_pulse <= w_accept;
      r_timeout   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_ARMED;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        ST_ARMED, ST_TRACKING: begin
          if (w_expired) begin
            // Timeout wins; a coincident tap restarts as a first tap.
            r_timeout <= 1'b1;
            r_cur     <= '0;
            r_prev    <= '0;
            if (w_accept) begin
              r_state <= ST_ARMED;
              r_cnt   <= CNT_W'(1);
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end
          end else if (w_accept) begin
            r_cnt   <= CNT_W'(1);
            r_valid <= 1'b1;
            if (r_state == ST_ARMED) begin
              r_state <= ST_TRACKING;
              r_cur   <= r_cnt;
              r_prev  <= r_cnt;
              r_index <= w_raw_idx;
              r_code  <= code_of(w_raw_idx);
            end else begin
              r_prev  <= r_cur;
              r_cur   <= r_cnt;
              r_index <= w_avg_idx;
              r_code  <= code_of(w_avg_idx);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_tempo_code  = r_code;
  assign o_tempo_index = r_index;
  assign o_code_valid  = r_valid;
  assign o_tap_pulse   = r_tap_pulse;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_tap_tempo_encoder.sv
// -----------------------------------------------------------------------------
// tb_tap_tempo_encoder
// Directed bench for tap_tempo_encoder. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a period after the active edge.
// -----------------------------------------------------------------------------
module tb_tap_tempo_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tap = 1'b0;
  logic [9:0] code;
  logic [3:0] idx;
  logic       valid;
  logic       pulse;
  logic       tmo;

  int n_err    = 0;
  int n_checks = 0;

  tap_tempo_encoder dut (
    .i_clk100hz   (clk),
    .i_reset      (rst),
    .i_tap        (tap),
    .o_tempo_code (code),
    .o_tempo_index(idx),
    .o_code_valid (valid),
    .o_tap_pulse  (pulse),
    .o_timeout    (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_outputs(input string tag, input int c, input int i, input int v);
    chk({tag, "_code"}, int'(code), c);
    chk({tag, "_index"}, int'(idx), i);
    chk({tag, "_valid"}, int'(valid), v);
  endtask

  // One-tick tap press; the strobe must appear exactly after the third edge.
  // Consumes 3 ticks, so taps issued N ticks apart are accepted N ticks apart.
  task automatic do_tap(input string tag, input int c, input int i, input int v,
                        input int exp_tmo);
    tap = 1'b1;
    @(negedge clk);
    tap = 1'b0;
    chk({tag, "_pulse_e0"}, int'(pulse), 0);
    @(negedge clk);
    chk({tag, "_pulse_e1"}, int'(pulse), 0);
    @(negedge clk);
    chk({tag, "_pulse_e2"}, int'(pulse), 1);
    chk({tag, "_timeout"}, int'(tmo), exp_tmo);
    chk_outputs(tag, c, i, v);
  endtask

  // Called right after an acceptance: timeout must strobe exactly n ticks later.
  task automatic expect_timeout(input string tag, input int n);
    int early;
    early = 0;
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      if (tmo) early++;
    end
    @(negedge clk);
    chk({tag, "_early"}, early, 0);
    chk({tag, "_strobe"}, int'(tmo), 1);
    @(negedge clk);
    chk({tag, "_one_cycle"}, int'(tmo), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int seen;

    // Reset values
    rst = 1'b1;
    tap = 1'b0;
    wait_ticks(3);
    rst = 1'b0;
    chk_outputs("reset", 350, 3, 0);
    chk("reset_pulse", int'(pulse), 0);
    chk("reset_timeout", int'(tmo), 0);

    // Silence for 1000 ticks: no strobes, stays at default
    seen = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (tmo || pulse) seen++;
    end
    chk("idle_strobes", seen, 0);
    chk_outputs("idle", 350, 3, 0);

    // Four taps 100 ticks apart
    do_tap("p100_t1", 350, 3, 0, 0);
    wait_ticks(97);
    do_tap("p100_t2", 350, 3, 1, 0);
    wait_ticks(97);
    do_tap("p100_t3", 350, 3, 1, 0);
    wait_ticks(97);
    do_tap("p100_t4", 350, 3, 1, 0);

    // Held tap with a re-rise 3 ticks after the first rise: one acceptance
    do_reset();
    seen = 0;
    tap = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 1) tap = 1'b0;
      else if (k == 2) tap = 1'b1;
      else if (k == 49) tap = 1'b0;
      if (pulse) seen++;
    end
    chk("bounce_pulses", seen, 1);
    chk_outputs("bounce", 350, 3, 0);

    // 100 then 300: raw first interval, then average of both
    do_reset();
    do_tap("mix_t1", 350, 3, 0, 0);
    wait_ticks(97);
    do_tap("mix_t2", 350, 3, 1, 0);
    wait_ticks(297);
    do_tap("mix_t3", 550, 5, 1, 0);

    // Timeout from TRACKING keeps the code
    expect_timeout("tmo_track", 500);
    chk_outputs("tmo_track_hold", 550, 5, 1);

    // Single tap then silence: timeout 500 ticks after acceptance
    do_tap("single", 550, 5, 1, 0);
    expect_timeout("tmo_single", 500);
    chk_outputs("tmo_single_hold", 550, 5, 1);

    // Two taps 25 apart
    do_tap("p25_t1", 550, 5, 1, 0);
    wait_ticks(22);
    do_tap("p25_t2", 150, 1, 1, 0);

    // Tap on the timeout edge: both strobes, tap restarts as first tap
    wait_ticks(497);
    do_tap("coinc", 150, 1, 1, 1);
    wait_ticks(37);
    do_tap("coinc_next", 250, 2, 1, 0);

    // Class boundaries on the raw first interval
    do_reset();
    do_tap("b17_t1", 350, 3, 0, 0);
    wait_ticks(14);
    do_tap("b17_t2", 50, 0, 1, 0);
    do_reset();
    do_tap("b18_t1", 350, 3, 0, 0);
    wait_ticks(15);
    do_tap("b18_t2", 150, 1, 1, 0);
    do_reset();
    do_tap("b374_t1", 350, 3, 0, 0);
    wait_ticks(371);
    do_tap("b374_t2", 850, 8, 1, 0);
    do_reset();
    do_tap("b375_t1", 350, 3, 0, 0);
    wait_ticks(372);
    do_tap("b375_t2", 960, 9, 1, 0);

    // Reset mid-ARMED with non-default outputs held
    expect_timeout("tmo_pre_rst", 500);
    do_tap("armed", 960, 9, 1, 0);
    wait_ticks(10);
    rst = 1'b1;
    @(negedge clk);
    chk_outputs("mid_reset", 350, 3, 0);
    chk("mid_reset_pulse", int'(pulse), 0);
    chk("mid_reset_timeout", int'(tmo), 0);
    rst = 1'b0;
    do_tap("post_rst_t1", 350, 3, 0, 0);
    wait_ticks(37);
    do_tap("post_rst_t2", 250, 2, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
